// File: rtl/project_7.sv
`default_nettype none
// ============================================================================
// Module   : project_7
// Desc     : Four-stage (IF, ID, EX, MEM/WB) 32-bit core for a reduced
//            MIPS-like ISA. Define PROJECT_7_FORWARD_EN for ID-stage forwarding.
// Revision : 1.0
// ============================================================================
module project_7 (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ibus,
   output logic [31:0] daddrbus,
   inout  wire  [31:0] databus
);

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_xori  = 6'b000001;
   localparam logic [5:0] c_op_subi  = 6'b000010;
   localparam logic [5:0] c_op_addi  = 6'b000011;
   localparam logic [5:0] c_op_ori   = 6'b001100;
   localparam logic [5:0] c_op_andi  = 6'b001111;
   localparam logic [5:0] c_op_lw    = 6'b011110;
   localparam logic [5:0] c_op_sw    = 6'b011111;

   localparam logic [5:0] c_fn_xor = 6'b000001;
   localparam logic [5:0] c_fn_sub = 6'b000010;
   localparam logic [5:0] c_fn_add = 6'b000011;
   localparam logic [5:0] c_fn_or  = 6'b000100;
   localparam logic [5:0] c_fn_and = 6'b000111;

   localparam logic [2:0] c_alu_add = 3'd0;
   localparam logic [2:0] c_alu_sub = 3'd1;
   localparam logic [2:0] c_alu_xor = 3'd2;
   localparam logic [2:0] c_alu_and = 3'd3;
   localparam logic [2:0] c_alu_or  = 3'd4;

   logic [31:0] r_regs [32];

   logic [31:0] r_ifid_instr;

   logic [31:0] r_idex_a, r_idex_b, r_idex_sd;
   logic [2:0]  r_idex_alu;
   logic [4:0]  r_idex_dest;
   logic        r_idex_lw, r_idex_sw;

   logic [31:0] r_exmem_res, r_exmem_sd;
   logic [4:0]  r_exmem_dest;
   logic        r_exmem_lw, r_exmem_sw;

   logic [5:0]  w_op, w_fn;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_imm;
   logic [2:0]  w_alu;
   logic [4:0]  w_dest;
   logic        w_useimm, w_lw, w_sw;
   logic [31:0] w_rs_val, w_rt_val;
   logic [31:0] w_ex_result, w_mem_result;
   logic        w_unused_shamt;

   assign w_op   = r_ifid_instr[31:26];
   assign w_rs   = r_ifid_instr[25:21];
   assign w_rt   = r_ifid_instr[20:16];
   assign w_rd   = r_ifid_instr[15:11];
   assign w_fn   = r_ifid_instr[5:0];
   assign w_imm  = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
   assign w_unused_shamt = ^r_ifid_instr[10:6];

   // Non-writing instructions carry dest 0, which also keeps them out of forwarding
   always_comb begin
      w_alu    = c_alu_add;
      w_dest   = 5'd0;
      w_useimm = 1'b1;
      w_lw     = 1'b0;
      w_sw     = 1'b0;
      case (w_op)
         c_op_addi: begin w_alu = c_alu_add; w_dest = w_rt; end
         c_op_subi: begin w_alu = c_alu_sub; w_dest = w_rt; end
         c_op_xori: begin w_alu = c_alu_xor; w_dest = w_rt; end
         c_op_andi: begin w_alu = c_alu_and; w_dest = w_rt; end
         c_op_ori:  begin w_alu = c_alu_or;  w_dest = w_rt; end
         c_op_lw:   begin w_dest = w_rt; w_lw = 1'b1; end
         c_op_sw:   w_sw = 1'b1;
         c_op_rtype: begin
            w_useimm = 1'b0;
            w_dest   = w_rd;
            case (w_fn)
               c_fn_add: w_alu = c_alu_add;
               c_fn_sub: w_alu = c_alu_sub;
               c_fn_xor: w_alu = c_alu_xor;
               c_fn_and: w_alu = c_alu_and;
               c_fn_or:  w_alu = c_alu_or;
               default:  w_dest = 5'd0;
            endcase
         end
         default: ;
      endcase
   end

   assign w_mem_result = r_exmem_lw ? databus : r_exmem_res;

   always_comb begin
      w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
      w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
`ifdef PROJECT_7_FORWARD_EN
      // A load in EX has no data yet, so it falls through to the MEM/regfile path
      if (w_rs != 5'd0 && w_rs == r_idex_dest && !r_idex_lw)
         w_rs_val = w_ex_result;
      else if (w_rs != 5'd0 && w_rs == r_exmem_dest)
         w_rs_val = w_mem_result;
      if (w_rt != 5'd0 && w_rt == r_idex_dest && !r_idex_lw)
         w_rt_val = w_ex_result;
      else if (w_rt != 5'd0 && w_rt == r_exmem_dest)
         w_rt_val = w_mem_result;
`endif
   end

   always_comb begin
      case (r_idex_alu)
         c_alu_sub: w_ex_result = r_idex_a - r_idex_b;
         c_alu_xor: w_ex_result = r_idex_a ^ r_idex_b;
         c_alu_and: w_ex_result = r_idex_a & r_idex_b;
         c_alu_or:  w_ex_result = r_idex_a | r_idex_b;
         default:   w_ex_result = r_idex_a + r_idex_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ifid_instr <= 32'd0;
         r_idex_a     <= 32'd0;
         r_idex_b     <= 32'd0;
         r_idex_sd    <= 32'd0;
         r_idex_alu   <= c_alu_add;
         r_idex_dest  <= 5'd0;
         r_idex_lw    <= 1'b0;
         r_idex_sw    <= 1'b0;
         r_exmem_res  <= 32'd0;
         r_exmem_sd   <= 32'd0;
         r_exmem_dest <= 5'd0;
         r_exmem_lw   <= 1'b0;
         r_exmem_sw   <= 1'b0;
      end else begin
         r_ifid_instr <= ibus;
         r_idex_a     <= w_rs_val;
         r_idex_b     <= w_useimm ? w_imm : w_rt_val;
         r_idex_sd    <= w_rt_val;
         r_idex_alu   <= w_alu;
         r_idex_dest  <= w_dest;
         r_idex_lw    <= w_lw;
         r_idex_sw    <= w_sw;
         r_exmem_res  <= w_ex_result;
         r_exmem_sd   <= r_idex_sd;
         r_exmem_dest <= r_idex_dest;
         r_exmem_lw   <= r_idex_lw;
         r_exmem_sw   <= r_idex_sw;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else if (r_exmem_dest != 5'd0) begin
         r_regs[r_exmem_dest] <= w_mem_result;
      end
   end

   assign daddrbus = r_exmem_res;
   assign databus  = r_exmem_sw ? r_exmem_sd : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_project_7.sv
`default_nettype none
// ============================================================================
// Module   : tb_project_7
// Desc     : Self-checking bench for project_7: directed vectors, a randomized
//            program against an architectural model, reset and forwarding cases.
// Revision : 1.0
// ============================================================================
module tb_project_7;

   localparam int c_op_xori = 1;
   localparam int c_op_subi = 2;
   localparam int c_op_addi = 3;
   localparam int c_op_ori  = 12;
   localparam int c_op_andi = 15;
   localparam int c_op_lw   = 30;
   localparam int c_op_sw   = 31;
   localparam logic [31:0] c_probe = 32'h5A5A_5A5A;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ibus;
   wire  [31:0] daddrbus;
   wire  [31:0] databus;
   logic        mem_en;
   logic [31:0] mem_val;

   always #5 clk = ~clk;

   assign databus = mem_en ? mem_val : 32'bz;

   project_7 dut (
      .clk      (clk),
      .reset    (reset),
      .ibus     (ibus),
      .daddrbus (daddrbus),
      .databus  (databus)
   );

   typedef struct {
      logic [31:0] instr;
      bit          drv;
      logic [31:0] mval;
      bit          chk_a;
      logic [31:0] ea;
      bit          chk_d;
      logic [31:0] ed;
   } vec_t;

   vec_t tab[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] m_arch [32];
   logic [31:0] m_wv [0:511];
   int          m_wd [0:511];
   bit          m_lw [0:511];

   function automatic logic [31:0] it(int op, int rs, int rt, int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] rr(int rs, int rt, int rd, int fn);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic push(logic [31:0] instr, bit drv, logic [31:0] mval,
                       bit ca, logic [31:0] ea, bit cd, logic [31:0] ed);
      vec_t v;
      v.instr = instr; v.drv = drv; v.mval = mval;
      v.chk_a = ca; v.ea = ea; v.chk_d = cd; v.ed = ed;
      tab.push_back(v);
   endtask

   task automatic nop();                                    push(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0); endtask
   task automatic alu(logic [31:0] i, logic [31:0] ea);    push(i, 1'b0, 32'd0, 1'b1, ea, 1'b0, 32'd0);         endtask
   task automatic st(logic [31:0] i, logic [31:0] ea, logic [31:0] ed); push(i, 1'b0, 32'd0, 1'b1, ea, 1'b1, ed); endtask
   task automatic ld(logic [31:0] i, logic [31:0] ea, logic [31:0] v);  push(i, 1'b1, v, 1'b1, ea, 1'b1, v);      endtask
   task automatic probe();                                  push(32'd0, 1'b1, c_probe, 1'b0, 32'd0, 1'b1, c_probe); endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; ibus = 32'd0; mem_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_en = 1'b1; mem_val = c_probe;
      #1;
      check("reset_daddr", daddrbus, 32'd0);
      check("reset_databus_z", databus, c_probe);
      mem_en = 1'b0;
   endtask

   // Entry k is captured at loop edge k and sits in MEM during the cycle before edge k+3
   task automatic run_table();
      int n;
      n = tab.size();
      for (int c = 0; c < n + 3; c++) begin
         int k;
         @(negedge clk);
         reset = 1'b0;
         ibus  = (c < n) ? tab[c].instr : 32'd0;
         k = c - 3;
         mem_en = 1'b0;
         if (k >= 0) begin
            mem_en  = tab[k].drv;
            mem_val = tab[k].mval;
         end
         #1;
         if (k >= 0) begin
            if (tab[k].chk_a) check($sformatf("daddr[%0d]", k), daddrbus, tab[k].ea);
            if (tab[k].chk_d) check($sformatf("databus[%0d]", k), databus, tab[k].ed);
         end
      end
      @(negedge clk);
      mem_en = 1'b0;
      tab.delete();
   endtask

   task automatic build_directed();
      tab.delete();
      alu(it(c_op_addi, 0, 20, 16'hFFFF), 32'hFFFF_FFFF);
      alu(it(c_op_addi, 0, 21, 1), 32'h1);
      alu(it(c_op_addi, 0, 22, 2), 32'h2);
      nop();
      ld(it(c_op_lw, 20, 24, 0), 32'hFFFF_FFFF, 32'hCCCC_CCCC);
      ld(it(c_op_lw, 21, 25, 0), 32'h0000_0001, 32'hAAAA_AAAA);
      st(it(c_op_sw, 22, 20, 16'h1000), 32'h0000_1002, 32'hFFFF_FFFF);
      st(it(c_op_sw, 0, 21, 2), 32'h0000_0002, 32'h0000_0001);
      nop();
      alu(rr(24, 25, 26, 3), 32'h7777_7776);
      alu(rr(24, 25, 27, 2), 32'h2222_2222);
      alu(rr(24, 0, 28, 7), 32'h0000_0000);
      alu(rr(24, 25, 29, 1), 32'h6666_6666);
      alu(rr(24, 25, 30, 4), 32'hEEEE_EEEE);
      st(it(c_op_sw, 26, 26, 0), 32'h7777_7776, 32'h7777_7776);
      st(it(c_op_sw, 27, 27, 0), 32'h2222_2222, 32'h2222_2222);
      st(it(c_op_sw, 28, 28, 0), 32'h0000_0000, 32'h0000_0000);
      st(it(c_op_sw, 29, 29, 0), 32'h6666_6666, 32'h6666_6666);
      st(it(c_op_sw, 30, 30, 0), 32'hEEEE_EEEE, 32'hEEEE_EEEE);
      alu(it(c_op_subi, 24, 10, 16'h6420), 32'hCCCC_68AC);
      alu(it(c_op_xori, 24, 11, 16'h6420), 32'hCCCC_A8EC);
      alu(it(c_op_ori,  24, 12, 16'h6420), 32'hCCCC_ECEC);
      alu(it(c_op_andi, 24, 18, 0), 32'h0);
      st(it(c_op_sw, 10, 0, 0), 32'hCCCC_68AC, 32'h0);
      st(it(c_op_sw, 11, 0, 0), 32'hCCCC_A8EC, 32'h0);
      st(it(c_op_sw, 12, 0, 0), 32'hCCCC_ECEC, 32'h0);
      st(it(c_op_sw, 18, 0, 16'h1000), 32'h0000_1000, 32'h0);
      alu(it(c_op_addi, 0, 0, 5), 32'h5);
      nop();
      nop();
      probe();
      st(it(c_op_sw, 0, 0, 3), 32'h3, 32'h0);
      ld(it(c_op_lw, 0, 2, 0), 32'h0, 32'h1357_9BDF);
   endtask

   // Architectural view: instruction k sees writes of instructions <= k-3,
   // plus (with forwarding) the results of k-1 (non-load) and k-2.
   function automatic logic [31:0] mread(int r, int k);
      if (r == 0) return 32'd0;
`ifdef PROJECT_7_FORWARD_EN
      if (k >= 1 && m_wd[k-1] == r && !m_lw[k-1]) return m_wv[k-1];
      if (k >= 2 && m_wd[k-2] == r) return m_wv[k-2];
`endif
      return m_arch[r];
   endfunction

   task automatic build_random(int n);
      tab.delete();
      for (int i = 0; i < 32; i++) m_arch[i] = 32'd0;
      for (int k = 0; k < n; k++) begin
         int kind, rs, rt, rd, op, fn;
         logic [15:0] imm;
         logic [31:0] sx, a, b, r, lv;
         vec_t v;
         if (k >= 3 && m_wd[k-3] != 0) m_arch[m_wd[k-3]] = m_wv[k-3];
         kind = $urandom_range(0, 9);
         rs = $urandom_range(0, 7);
         rt = $urandom_range(0, 7);
         rd = $urandom_range(0, 7);
         imm = 16'($urandom);
         sx = {{16{imm[15]}}, imm};
         a = mread(rs, k);
         b = mread(rt, k);
         r = 32'd0; op = 0; fn = 0; lv = 32'd0;
         m_wd[k] = 0; m_lw[k] = 1'b0; m_wv[k] = 32'd0;
         v.drv = 1'b0; v.mval = 32'd0; v.chk_a = 1'b0; v.ea = 32'd0; v.chk_d = 1'b0; v.ed = 32'd0;
         case (kind)
            0: begin op = c_op_addi; r = a + sx; end
            1: begin op = c_op_subi; r = a - sx; end
            2: begin op = c_op_xori; r = a ^ sx; end
            3: begin op = c_op_andi; r = a & sx; end
            4: begin op = c_op_ori;  r = a | sx; end
            5: begin op = c_op_lw;   r = a + sx; lv = $urandom; end
            6: begin op = c_op_sw;   r = a + sx; end
            7: begin
               case ($urandom_range(0, 4))
                  0: begin fn = 3; r = a + b; end
                  1: begin fn = 2; r = a - b; end
                  2: begin fn = 1; r = a ^ b; end
                  3: begin fn = 7; r = a & b; end
                  default: begin fn = 4; r = a | b; end
               endcase
            end
            8: begin
               case ($urandom_range(0, 2))
                  0: fn = 0;
                  1: fn = 5;
                  default: fn = 63;
               endcase
            end
            default: begin
               case ($urandom_range(0, 2))
                  0: op = 4;
                  1: op = 32;
                  default: op = 58;
               endcase
            end
         endcase
         if (kind == 7 || kind == 8) v.instr = rr(rs, rt, rd, fn);
         else                        v.instr = it(op, rs, rt, int'(imm));
         if (kind <= 7) begin v.chk_a = 1'b1; v.ea = r; end
         if (kind <= 4) begin m_wd[k] = rt; m_wv[k] = r; end
         if (kind == 7) begin m_wd[k] = rd; m_wv[k] = r; end
         if (kind == 5) begin
            m_wd[k] = rt; m_wv[k] = lv; m_lw[k] = 1'b1;
            v.drv = 1'b1; v.mval = lv; v.chk_d = 1'b1; v.ed = lv;
         end
         if (kind == 6) begin v.chk_d = 1'b1; v.ed = b; end
         tab.push_back(v);
      end
   endtask

   task automatic step(logic [31:0] instr);
      @(negedge clk);
      reset = 1'b0;
      ibus  = instr;
   endtask

   task automatic reset_in_flight();
      do_reset();
      step(it(c_op_addi, 0, 5, 3));
      step(32'd0);
      step(32'd0);
      step(32'd0);
      step(it(c_op_sw, 5, 5, 16'h40));
      step(32'd0);
      @(negedge clk);
      reset = 1'b1; ibus = 32'd0;
      @(negedge clk);
      mem_en = 1'b1; mem_val = c_probe;
      #1;
      check("inflight_daddr", daddrbus, 32'd0);
      check("inflight_databus_z", databus, c_probe);
      mem_en = 1'b0;
      tab.delete();
      st(it(c_op_sw, 5, 5, 16'h10), 32'h10, 32'h0);
      run_table();
   endtask

   task automatic build_fwd();
      tab.delete();
      alu(it(c_op_addi, 0, 1, 7), 32'h7);
`ifdef PROJECT_7_FORWARD_EN
      st(it(c_op_sw, 1, 1, 0), 32'h7, 32'h7);
      ld(it(c_op_lw, 0, 2, 0), 32'h0, 32'h0000_0099);
      nop();
      alu(it(c_op_addi, 2, 3, 1), 32'h0000_009A);
`else
      st(it(c_op_sw, 1, 1, 0), 32'h0, 32'h0);
      ld(it(c_op_lw, 0, 2, 0), 32'h0, 32'h0000_0099);
      nop();
      alu(it(c_op_addi, 2, 3, 1), 32'h0000_0001);
`endif
   endtask

   initial begin
      reset = 1'b1; ibus = 32'd0; mem_en = 1'b0; mem_val = 32'd0;
      do_reset();
      build_directed();
      run_table();
      do_reset();
      build_random(250);
      run_table();
      reset_in_flight();
      do_reset();
      build_fwd();
      run_table();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
